// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller: lane-selects and extends sub-word loads, and
// performs sub-word stores as a two-cycle read-modify-write on a word-wide port.
module lsu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic {IDLE, MERGE} state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  state_t      state;
  logic [29:0] m_addr;   // captured word address
  logic [1:0]  m_lane;
  logic        m_half;
  logic [15:0] m_data;
  logic [31:0] m_pc;
  logic [31:0] m_word;   // memory word read in the accept cycle

  logic        aligned;
  logic        is_load;
  logic        accept;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign req_ready = (state == IDLE);

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    aligned = 1'b1;
    case (req_op)
      OP_LW, OP_SW:         aligned = (req_addr[1:0] == 2'b00);
      OP_LH, OP_LHU, OP_SH: aligned = (req_addr[0] == 1'b0);
      default:              aligned = 1'b1;
    endcase

    is_load = (req_op <= OP_LBU);
    accept  = req_valid && req_ready && !reset;

    ld_byte = mem_rd[{req_addr[1:0], 3'b000} +: 8];
    ld_half = req_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    ld_data = mem_rd;
    case (req_op)
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'h0000, ld_half};
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'h000000, ld_byte};
      default: ld_data = mem_rd;
    endcase

    merged = m_word;
    if (m_half) begin
      merged[{m_lane[1], 4'b0000} +: 16] = m_data;
    end else begin
      merged[{m_lane, 3'b000} +: 8] = m_data[7:0];
    end

    // Reset wins over a pending merge write; the port idles on the request.
    mem_addr = {req_addr[31:2], 2'b00};
    mem_pc   = req_pc;
    mem_we   = 1'b0;
    mem_wd   = 32'h0;
    if (state == MERGE && !reset) begin
      mem_we   = 1'b1;
      mem_addr = {m_addr, 2'b00};
      mem_pc   = m_pc;
      mem_wd   = merged;
    end else if (accept && aligned && req_op == OP_SW) begin
      mem_we = 1'b1;
      mem_wd = req_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      m_addr     <= '0;
      m_lane     <= '0;
      m_half     <= 1'b0;
      m_data     <= '0;
      m_pc       <= '0;
      m_word     <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!aligned) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (is_load) begin
              resp_valid <= 1'b1;
              resp_rdata <= ld_data;
            end else if (req_op == OP_SW) begin
              resp_valid <= 1'b1;
            end else begin
              m_addr <= req_addr[31:2];
              m_lane <= req_addr[1:0];
              m_half <= (req_op == OP_SH);
              m_data <= req_wdata[15:0];
              m_pc   <= req_pc;
              m_word <= mem_rd;
              state  <= MERGE;
            end
          end
        end
        MERGE: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus a random op mix checked
// against a byte-addressed memory model.
module tb_lsu_ctrl;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
  localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_pc = 32'h0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_pc;
  logic [31:0] mem_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] dmem [0:4095];
  logic [7:0]  rmem [0:16383];

  lsu_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_pc(mem_pc),
    .mem_rd(mem_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  assign mem_rd = dmem[mem_addr[13:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[13:2]] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [13:0] b;
    b = {a[13:2], 2'b00};
    return {rmem[b + 14'd3], rmem[b + 14'd2], rmem[b + 14'd1], rmem[b]};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
    logic [13:0] b;
    logic [15:0] h;
    b = a[13:0];
    h = {rmem[b + 14'd1], rmem[b]};
    case (op)
      LB:      return {{24{rmem[b][7]}}, rmem[b]};
      LBU:     return {24'h0, rmem[b]};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'h0, h};
      default: return model_word(a);
    endcase
  endfunction

  task automatic model_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int nbytes;
    nbytes = (op == SW) ? 4 : (op == SH) ? 2 : 1;
    for (int k = 0; k < nbytes; k++) rmem[a[13:0] + 14'(k)] = d[8*k +: 8];
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    dmem[a[13:2]] = w;
    for (int k = 0; k < 4; k++) rmem[{a[13:2], 2'b00} + 14'(k)] = w[8*k +: 8];
  endtask

  // Called about 1 time unit after a falling edge; returns at the same phase.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] pc, output logic [31:0] rdata, output logic err);
    logic        mis, sub_st, exp_we;
    logic [31:0] exp_ld, exp_word;
    int          n;
    mis    = (op == LW || op == SW) ? (a[1:0] != 2'b00) :
             (op == LH || op == LHU || op == SH) ? a[0] : 1'b0;
    sub_st = (op == SH || op == SB) && !mis;
    exp_we = (op == SW) && !mis;
    exp_ld = (op <= LBU && !mis) ? model_load(op, a) : 32'h0;
    if (op >= SW && !mis) model_store(op, a, d);
    exp_word = model_word(a);

    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d; req_pc = pc;
    #1;
    n = 0;
    while (!req_ready && n < 4) begin
      @(negedge clk); #1; n++;
    end
    check("accept_ready", req_ready, 1);
    check("accept_addr", mem_addr, {a[31:2], 2'b00});
    check("accept_pc", mem_pc, pc);
    check("accept_we", mem_we, exp_we);
    check("accept_wd", mem_wd, exp_we ? d : 32'h0);

    @(negedge clk); #1;
    req_valid = 1'b0;
    #1;
    if (sub_st) begin
      check("merge_ready", req_ready, 0);
      check("merge_we", mem_we, 1);
      check("merge_addr", mem_addr, {a[31:2], 2'b00});
      check("merge_pc", mem_pc, pc);
      check("merge_wd", mem_wd, exp_word);
      check("merge_no_resp", resp_valid, 0);
      @(negedge clk); #2;
    end
    check("resp_valid", resp_valid, 1);
    check("resp_err", resp_err, mis);
    check("resp_rdata", resp_rdata, exp_ld);
    check("resp_we_idle", mem_we, 0);
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic        er;
    logic [2:0]  op;

    for (int i = 0; i < 4096; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 16384; i++) rmem[i] = 8'h0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_we", mem_we, 0);
    reset = 1'b0;
    @(negedge clk); #1;
    check("rst_ready", req_ready, 1);
    check("rst_no_resp", resp_valid, 0);

    // Sub-word load extension
    poke(32'h10, 32'h8001_7F80);
    do_op(LB, 32'h10, 32'h0, 32'h100, rd, er);  check("lb_10", rd, 32'hFFFF_FF80);
    do_op(LBU, 32'h10, 32'h0, 32'h104, rd, er); check("lbu_10", rd, 32'h0000_0080);
    do_op(LB, 32'h11, 32'h0, 32'h108, rd, er);  check("lb_11", rd, 32'h0000_007F);
    do_op(LH, 32'h12, 32'h0, 32'h10C, rd, er);  check("lh_12", rd, 32'hFFFF_8001);
    do_op(LHU, 32'h12, 32'h0, 32'h110, rd, er); check("lhu_12", rd, 32'h0000_8001);
    do_op(LW, 32'h10, 32'h0, 32'h114, rd, er);  check("lw_10", rd, 32'h8001_7F80);

    // Byte store read-modify-write, then read back
    poke(32'h20, 32'h1122_3344);
    do_op(SB, 32'h21, 32'h0000_00AB, 32'h200, rd, er);
    check("sb_mem", dmem[8], 32'h1122_AB44);
    do_op(LW, 32'h20, 32'h0, 32'h204, rd, er);  check("sb_readback", rd, 32'h1122_AB44);

    // Halfword store with a word store held through the MERGE cycle
    poke(32'h20, 32'hFFFF_FFFF);
    req_valid = 1'b1; req_op = SH; req_addr = 32'h22; req_wdata = 32'h0000_BEEF; req_pc = 32'h300;
    #1;
    check("sh_accept_ready", req_ready, 1);
    model_store(SH, 32'h22, 32'h0000_BEEF);
    @(negedge clk); #1;
    req_op = SW; req_addr = 32'h24; req_wdata = 32'h1234_5678; req_pc = 32'h304;
    #1;
    check("sh_merge_ready", req_ready, 0);
    check("sh_merge_we", mem_we, 1);
    check("sh_merge_wd", mem_wd, 32'hBEEF_FFFF);
    check("sh_merge_addr", mem_addr, 32'h20);
    check("sh_merge_pc", mem_pc, 32'h300);
    @(negedge clk); #1;
    check("sh_resp_valid", resp_valid, 1);
    check("sw_t2_ready", req_ready, 1);
    check("sw_t2_we", mem_we, 1);
    check("sw_t2_wd", mem_wd, 32'h1234_5678);
    check("sw_t2_addr", mem_addr, 32'h24);
    model_store(SW, 32'h24, 32'h1234_5678);
    @(negedge clk); #1;
    req_valid = 1'b0;
    #1;
    check("sw_resp_valid", resp_valid, 1);
    check("sw_resp_rdata", resp_rdata, 0);
    check("sh_mem", dmem[8], 32'hBEEF_FFFF);
    do_op(LW, 32'h24, 32'h0, 32'h308, rd, er);  check("sw_readback", rd, 32'h1234_5678);

    // Misaligned accesses
    do_op(LW, 32'h06, 32'h0, 32'h400, rd, er);  check("mis_lw_err", er, 1);
    do_op(LH, 32'h03, 32'h0, 32'h404, rd, er);  check("mis_lh_err", er, 1);
    do_op(SW, 32'h02, 32'hDEAD_BEEF, 32'h408, rd, er); check("mis_sw_err", er, 1);
    check("mis_sw_mem", dmem[0], 32'h0);

    // Reset during MERGE drops the pending store
    poke(32'h30, 32'hCAFE_F00D);
    req_valid = 1'b1; req_op = SB; req_addr = 32'h31; req_wdata = 32'h55; req_pc = 32'h500;
    #1;
    check("rm_accept_ready", req_ready, 1);
    @(negedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    #1;
    check("rm_we", mem_we, 0);
    check("rm_wd", mem_wd, 0);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("rm_no_resp", resp_valid, 0);
    check("rm_ready", req_ready, 1);
    @(negedge clk); #1;
    check("rm_no_resp2", resp_valid, 0);
    check("rm_mem", dmem[12], 32'hCAFE_F00D);

    // Reset in an accept cycle accepts nothing
    reset = 1'b1;
    req_valid = 1'b1; req_op = SW; req_addr = 32'h34; req_wdata = 32'hDEAD_BEEF; req_pc = 32'h600;
    #1;
    check("ra_we", mem_we, 0);
    @(negedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    #1;
    check("ra_no_resp", resp_valid, 0);
    check("ra_mem", dmem[13], model_word(32'h34));

    // Random mix against the byte model
    for (int i = 0; i < 1000; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 8) begin
        if (op == LW || op == SW) a[1:0] = 2'b00;
        else if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
      end
      d = $urandom;
      do_op(op, a, d, $urandom, rd, er);
    end
    for (int w = 0; w < 64; w++) check("final_mem", dmem[w], model_word(32'(w * 4)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller for the MEM stage of the pipelined CPU. It turns byte, halfword and word load/store requests into accesses on the word-wide data memory port: address, single write enable, write data, combinational read data, and the PC of the store. Sub-word stores are done as a read-modify-write over two cycles, with a stall to the pipeline. Sub-word loads are lane-selected and extended. Misaligned accesses are blocked and reported.

## Interface
- No parameters. Data width is fixed at 32 bits. Memory is word-addressed through addr[13:2].
- clk  in  1  sole clock; everything is on posedge clk
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present; must be held until accepted
- req_ready  out  1  high exactly when state is IDLE; a request is accepted on a cycle with req_valid && req_ready
- req_op  in  3  encodings: 0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu, 5=sw, 6=sh, 7=sb
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low byte or halfword is used for sb/sh
- req_pc  in  32  PC of the instruction
- mem_addr  out  32  word-aligned address to memory (bits 1:0 always 0)
- mem_we  out  1  memory write enable
- mem_wd  out  32  memory write data
- mem_pc  out  32  PC forwarded to memory for its write trace
- mem_rd  in  32  combinational read data for mem_addr
- resp_valid  out  1  one-cycle pulse that completes a request
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_err  out  1  misaligned access; valid with resp_valid

## Operation
- States are IDLE and MERGE.
- Alignment rules:
  - lw/sw require addr[1:0]==0.
  - lh/lhu/sh require addr[0]==0.
  - byte ops are always aligned.
- In IDLE, mem_addr = {req_addr[31:2],2'b00} and mem_pc = req_pc, combinationally.
- Accepted load, aligned:
  - select lane from mem_rd in the same cycle (little-endian; byte k = bits 8k+7:8k; halfword at addr[1]).
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - register result into resp_rdata; stay in IDLE.
- Accepted sw, aligned: mem_we=1 and mem_wd=req_wdata in the accept cycle; stay in IDLE.
- Accepted sb/sh:
  - capture the word address, lane, op, data, pc and mem_rd into a merge register.
  - go to MERGE; no write in the accept cycle.
- MERGE (exactly 1 cycle):
  - mem_we=1 and mem_addr/mem_pc come from the captured values.
  - mem_wd is the captured word with only the target byte or halfword replaced.
  - req_ready=0; next state is IDLE.
- Misaligned request: accepted, but mem_we stays 0 and the state stays IDLE. The response has resp_err=1 and resp_rdata=0.
- mem_we is never asserted outside the accept cycle of an aligned sw and the MERGE cycle.
- mem_addr/mem_wd/mem_pc when mem_we=0: mem_wd=0; mem_addr/mem_pc follow the IDLE rule.

## Timing
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, merge registers 0. req_ready=1 in the cycle after reset deasserts.
- Loads, sw, and errors: resp_valid is asserted 1 cycle after acceptance.
- sb/sh sequence:
  - accept at cycle T.
  - write at T+1 (MERGE).
  - resp_valid at T+2.
  - req_ready=0 only at T+1.
- Back-to-back: a new request may be accepted in the same cycle that resp_valid of the previous one is high. Throughput is 1/cycle for loads/sw and 1 per 2 cycles for sb/sh.
- Load following an sb/sh to the same word (accepted at T+2) reads the merged value.
- req_valid high during MERGE is ignored. The requester holds it; it is accepted at T+2.
- Reset during MERGE:
  - no write that cycle (reset has priority; mem_we=0 while reset is high).
  - the pending store is dropped; no resp_valid.
- Reset in an accept cycle: nothing is accepted, mem_we=0.

## Test plan
- Memory word 0x10 holds 0x8001_7F80. Issue lb/lbu/lh/lhu/lw at 0x10..0x13 as appropriate. Expected: lb@0x10 -> 0xFFFF_FF80; lbu@0x10 -> 0x80; lb@0x11 -> 0x7F; lh@0x12 -> 0xFFFF_8001; lhu@0x12 -> 0x8001; lw -> 0x8001_7F80. Each response arrives 1 cycle after accept.
- Word holds 0x1122_3344; sb 0xAB at 0x21. Expected: req_ready low 1 cycle, the single write has mem_wd=0x1122_AB44, resp at T+2, and a following lw returns 0x1122_AB44.
- sh 0xBEEF at 0x22 onto 0xFFFF_FFFF. Expected: write 0xBEEF_FFFF. Issue sw 0x1234_5678 at 0x24 immediately after. Expected: it is accepted at T+2 and written at T+2.
- Misaligned lw@0x06, lh@0x03, sw@0x02. Expected: resp_err=1, resp_rdata=0, mem_we never high.
- sb accepted, then reset asserted in MERGE. Expected: no mem_we, no resp_valid, state IDLE, memory word unchanged.
- Random mix of 1000 ops against a byte-array model. Expected: all load results and the final memory contents match the model.
